// File: rtl/debounced_edge_detector_pkg.sv
// rtl/debounced_edge_detector_pkg.sv - shared types and defaults for the debounced edge detector
package edge_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_BOTH = 2'b11
  } edge_mode_e;

  localparam int N_CH_DEFAULT            = 4;
  localparam int SYNC_STAGES_DEFAULT     = 2;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 16;

  // One spare bit so DEBOUNCE_CYCLES-1 always fits, including power-of-two counts.
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles) + 1;
  endfunction

endpackage

// File: rtl/debounced_edge_detector_if.sv
// rtl/debounced_edge_detector_if.sv - level inputs, mode/clear controls and event outputs
interface debounced_edge_detector_if
  import edge_pkg::*;
#(
  parameter int N_CH = N_CH_DEFAULT
);

  logic [N_CH-1:0]   a_i;
  logic [2*N_CH-1:0] mode_i;
  logic [N_CH-1:0]   clear_i;
  logic [N_CH-1:0]   level_o;
  logic [N_CH-1:0]   rising_edge_o;
  logic [N_CH-1:0]   falling_edge_o;
  logic [N_CH-1:0]   event_o;
  logic [N_CH-1:0]   pending_o;

  modport master (
    output a_i, mode_i, clear_i,
    input  level_o, rising_edge_o, falling_edge_o, event_o, pending_o
  );

  modport slave (
    input  a_i, mode_i, clear_i,
    output level_o, rising_edge_o, falling_edge_o, event_o, pending_o
  );

endinterface

// File: rtl/debounced_edge_detector_channel.sv
// rtl/debounced_edge_detector_channel.sv - one channel: synchroniser, stability counter, level, edge pulses
module debounce_channel
  import edge_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic a,
  output logic level,
  output logic rising_edge,
  output logic falling_edge,
  output logic rise_take,
  output logic fall_take
);

  localparam int             CW   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic                   sync;
  logic                   take;

  assign sync      = sync_q[SYNC_STAGES-1];
  assign take      = (sync != level) && (cnt_q == LAST);
  assign rise_take = take & sync;
  assign fall_take = take & ~sync;

  // The counter saturates at LAST: reaching it with a mismatch accepts the level and reloads 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q       <= '0;
      cnt_q        <= '0;
      level        <= 1'b0;
      rising_edge  <= 1'b0;
      falling_edge <= 1'b0;
    end else begin
      sync_q       <= {sync_q[SYNC_STAGES-2:0], a};
      rising_edge  <= rise_take;
      falling_edge <= fall_take;
      if (sync == level) begin
        cnt_q <= '0;
      end else if (take) begin
        cnt_q <= '0;
        level <= sync;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/debounced_edge_detector.sv
// rtl/debounced_edge_detector.sv - N_CH debounced channels with per-channel mode filter and sticky pending
module debounced_edge_detector
  import edge_pkg::*;
#(
  parameter int N_CH            = N_CH_DEFAULT,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input logic                      clk,
  input logic                      reset,
  debounced_edge_detector_if.slave bus
);

  logic [N_CH-1:0] level;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] fall;
  logic [N_CH-1:0] rise_take;
  logic [N_CH-1:0] fall_take;
  logic [N_CH-1:0] event_d;
  logic [N_CH-1:0] event_q;
  logic [N_CH-1:0] pending_q;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .a            (bus.a_i[c]),
      .level        (level[c]),
      .rising_edge  (rise[c]),
      .falling_edge (fall[c]),
      .rise_take    (rise_take[c]),
      .fall_take    (fall_take[c])
    );
  end

  // Filter the pre-register accept strobes so event_o lands in the same cycle as the edge pulses.
  always_comb begin
    event_d = '0;
    for (int c = 0; c < N_CH; c++) begin
      case (edge_mode_e'(bus.mode_i[2*c +: 2]))
        MODE_RISE: event_d[c] = rise_take[c];
        MODE_FALL: event_d[c] = fall_take[c];
        MODE_BOTH: event_d[c] = rise_take[c] | fall_take[c];
        default:   event_d[c] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      event_q   <= '0;
      pending_q <= '0;
    end else begin
      event_q   <= event_d;
      pending_q <= event_q | (pending_q & ~bus.clear_i);
    end
  end

  assign bus.level_o        = level;
  assign bus.rising_edge_o  = rise;
  assign bus.falling_edge_o = fall;
  assign bus.event_o        = event_q;
  assign bus.pending_o      = pending_q;

endmodule

// File: doc/debounced_edge_detector.md
DEBOUNCED_EDGE_DETECTOR -- requirements
Module: debounced_edge_detector

Interface
REQ-001 Parameter N_CH, default 4: number of independent input channels, legal range 1..32.
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser flops per channel, legal range 2..4.
REQ-003 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles needed to accept a new level, legal range 1..65535.
REQ-004 clk  input  1  clock; all flops SHALL be clocked on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 a_i  input  N_CH  raw asynchronous level inputs, one bit per channel.
REQ-007 mode_i  input  2*N_CH  per-channel event mode of type edge_mode_e: 00 OFF, 01 RISE, 10 FALL, 11 BOTH.
REQ-008 clear_i  input  N_CH  per-channel clear of the sticky pending flag.
REQ-009 level_o  output  N_CH  debounced, accepted level.
REQ-010 rising_edge_o  output  N_CH  one-cycle pulse when level_o goes 0->1.
REQ-011 falling_edge_o  output  N_CH  one-cycle pulse when level_o goes 1->0.
REQ-012 event_o  output  N_CH  one-cycle pulse for each edge selected by mode_i.
REQ-013 pending_o  output  N_CH  sticky flag, set by event_o and cleared by clear_i.

Function
REQ-014 Each channel SHALL pass a_i through a SYNC_STAGES flop chain; only the last stage (sync) SHALL feed the logic below.
REQ-015 Each channel SHALL hold a counter of width $clog2(DEBOUNCE_CYCLES)+1 and the accepted level register level_o.
REQ-016 While sync == level_o, the counter SHALL load 0 on every clock.
REQ-017 While sync != level_o and counter < DEBOUNCE_CYCLES-1, the counter SHALL increment by 1.
REQ-018 While sync != level_o and counter == DEBOUNCE_CYCLES-1, on that clock: level_o <= sync, counter <= 0, and the matching edge register <= 1.
REQ-019 A glitch shorter than DEBOUNCE_CYCLES synchronised cycles SHALL reset the counter and SHALL produce no edge.
REQ-020 The counter SHALL never wrap.
REQ-021 Latency: count the clock edge that first samples a new held level as edge 1. level_o, the edge pulse and event_o SHALL update at edge SYNC_STAGES+DEBOUNCE_CYCLES (edge 6 for 2/4).
REQ-022 rising_edge_o and falling_edge_o SHALL be registered, SHALL be high for exactly one cycle, and SHALL never both be high on the same channel.
REQ-023 event_o SHALL be registered and SHALL be cycle-aligned with the edge pulses, evaluated as: OFF = 0; RISE = rising; FALL = falling; BOTH = rising | falling.
REQ-024 mode_i SHALL be sampled in the cycle in which the edge is accepted; a mode change never creates or cancels an already-emitted pulse.
REQ-025 pending_o SHALL set on the clock after event_o is asserted; clear_i high SHALL clear it on the next clock.
REQ-026 If set and clear_i occur in the same cycle, set SHALL win.
REQ-027 Channels SHALL be fully independent; simultaneous edges on multiple channels SHALL all be reported in the same cycle.

Reset
REQ-028 On reset, the sync flops, counter, level_o, rising_edge_o, falling_edge_o, event_o and pending_o SHALL all go to 0 immediately.
REQ-029 Reset asserted mid-debounce SHALL discard the partial count; no pulse SHALL be emitted for it.
REQ-030 An input held high through reset release SHALL produce exactly one rising edge, SYNC_STAGES+DEBOUNCE_CYCLES edges after release.

Structure
REQ-031 Package edge_pkg SHALL hold edge_mode_e, the parameter defaults, and a function returning the counter width.
REQ-032 Sub-module debounce_channel SHALL implement one channel (sync, counter, level, edge pulses).
REQ-033 The top level SHALL instantiate debounce_channel N_CH times in a generate loop and SHALL implement the mode filter and pending logic.

Verification
REQ-034 N_CH=4, S=2, D=4, mode RISE: a_i[0] 0->1 held -> rising_edge_o[0], event_o[0] high at edge 6 only; pending_o[0]=1 from edge 7.
REQ-035 Glitch a_i[1]=1 for 3 cycles with D=4 -> level_o, all pulses and pending remain 0.
REQ-036 mode BOTH on ch2, square wave with 10-cycle half period -> event_o[2] pulses on every transition, alternating rising/falling.
REQ-037 Set and clear_i[0] in the same cycle -> pending_o[0] stays 1; clear_i alone next cycle -> 0.
REQ-038 Reset asserted at count 2 during a rise -> all outputs 0, no pulse; a_i held 1 -> single rising pulse at edge 6 after release.
REQ-039 D=1, mode OFF on ch3 with toggling input -> rising/falling pulses present at latency SYNC_STAGES+1, event_o[3] and pending_o[3] stay 0.
